// File: rtl/aes_package.sv
// Shared types and constants for the AES word packer.
package aes_package;

   localparam int AES_WORD_W      = 32;
   localparam int AES_BLOCK_WORDS = 4;
   localparam int AES_BLOCK_W     = AES_WORD_W * AES_BLOCK_WORDS;
   localparam int AES_WIDX_W      = $clog2(AES_BLOCK_WORDS);
   localparam int AES_LSB_W       = $clog2(AES_BLOCK_W);

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      PACK    = 3'd1,
      ISSUE   = 3'd2,
      WAIT_CT = 3'd3,
      UNPACK  = 3'd4,
      DONE    = 3'd5
   } aes_pack_state_t;

   // Bit offset of word 'idx' inside a 128-bit block; word 0 sits in the LSBs.
   function automatic logic [AES_LSB_W-1:0] word_lsb(input logic [AES_WIDX_W-1:0] idx);
      return AES_LSB_W'(idx) << $clog2(AES_WORD_W);
   endfunction

endpackage

// File: rtl/aes_word_packer_if.sv
// Stream and block handshake bundle between the packer and its neighbours.
// master: the packer itself; slave: source streamer, cipher core and sink.
interface aes_word_packer_if;
   import aes_package::*;

   logic [AES_WORD_W-1:0]  pt_data_i;
   logic                   pt_valid_i;
   logic                   pt_ready_o;

   logic [AES_BLOCK_W-1:0] blk_data_o;
   logic                   blk_valid_o;
   logic                   blk_ready_i;

   logic [AES_BLOCK_W-1:0] ct_blk_i;
   logic                   ct_valid_i;
   logic                   ct_ready_o;

   logic [AES_WORD_W-1:0]  ct_data_o;
   logic                   ct_valid_o;
   logic                   ct_ready_i;

   modport master (
      input  pt_data_i, pt_valid_i, blk_ready_i, ct_blk_i, ct_valid_i, ct_ready_i,
      output pt_ready_o, blk_data_o, blk_valid_o, ct_ready_o, ct_data_o, ct_valid_o
   );

   modport slave (
      output pt_data_i, pt_valid_i, blk_ready_i, ct_blk_i, ct_valid_i, ct_ready_i,
      input  pt_ready_o, blk_data_o, blk_valid_o, ct_ready_o, ct_data_o, ct_valid_o
   );

endinterface

// File: rtl/aes_word_packer.sv
// Packs four 32-bit plaintext words into a 128-bit block for the cipher core,
// then unpacks the returned ciphertext block into four words, LSB word first.
// All handshake outputs come straight from flops (gated only by enable), so
// no ready->valid combinational path exists on any side.
module aes_word_packer
   import aes_package::*;
#(
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             clear,
   input  logic             start,
   input  logic             enable,
   input  logic [CNT_W-1:0] num_blocks_i,
   output logic             busy_o,
   output logic             done_o,
   aes_word_packer_if.master bus
);

   localparam logic [AES_WIDX_W-1:0] LAST_WORD = AES_WIDX_W'(AES_BLOCK_WORDS - 1);

   aes_pack_state_t        state;
   logic [CNT_W-1:0]       num_q;
   logic [CNT_W-1:0]       blk_cnt;
   logic [AES_WIDX_W-1:0]  word_idx;
   logic [AES_BLOCK_W-1:0] blk_q;
   logic [AES_BLOCK_W-1:0] ct_q;

   logic pt_rdy_q, blk_vld_q, ct_rdy_q, ct_vld_q;
   logic pt_fire, blk_fire, ct_in_fire, ct_out_fire;

   // enable=0 drops every handshake output immediately without touching state
   assign bus.pt_ready_o  = pt_rdy_q  & enable;
   assign bus.blk_valid_o = blk_vld_q & enable;
   assign bus.ct_ready_o  = ct_rdy_q  & enable;
   assign bus.ct_valid_o  = ct_vld_q  & enable;
   assign bus.blk_data_o  = blk_q;
   assign bus.ct_data_o   = ct_q[word_lsb(word_idx) +: AES_WORD_W];
   assign busy_o          = (state != IDLE);

   assign pt_fire     = bus.pt_valid_i & bus.pt_ready_o;
   assign blk_fire    = bus.blk_valid_o & bus.blk_ready_i;
   assign ct_in_fire  = bus.ct_valid_i & bus.ct_ready_o;
   assign ct_out_fire = bus.ct_valid_o & bus.ct_ready_i;

   // Job sequencer: state, counters, data registers and registered handshake flags
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state     <= IDLE;
         num_q     <= '0;
         blk_cnt   <= '0;
         word_idx  <= '0;
         blk_q     <= '0;
         ct_q      <= '0;
         pt_rdy_q  <= 1'b0;
         blk_vld_q <= 1'b0;
         ct_rdy_q  <= 1'b0;
         ct_vld_q  <= 1'b0;
         done_o    <= 1'b0;
      end else begin
         done_o <= 1'b0;
         if (clear) begin
            state     <= IDLE;
            blk_cnt   <= '0;
            word_idx  <= '0;
            pt_rdy_q  <= 1'b0;
            blk_vld_q <= 1'b0;
            ct_rdy_q  <= 1'b0;
            ct_vld_q  <= 1'b0;
         end else if (enable) begin
            case (state)
               IDLE: begin
                  if (start) begin
                     num_q    <= num_blocks_i;
                     blk_cnt  <= '0;
                     word_idx <= '0;
                     if (num_blocks_i == '0) begin
                        state <= DONE;
                     end else begin
                        state    <= PACK;
                        pt_rdy_q <= 1'b1;
                     end
                  end
               end
               PACK: begin
                  if (pt_fire) begin
                     blk_q[word_lsb(word_idx) +: AES_WORD_W] <= bus.pt_data_i;
                     if (word_idx == LAST_WORD) begin
                        word_idx  <= '0;
                        pt_rdy_q  <= 1'b0;
                        blk_vld_q <= 1'b1;
                        state     <= ISSUE;
                     end else begin
                        word_idx <= word_idx + 1'b1;
                     end
                  end
               end
               ISSUE: begin
                  if (blk_fire) begin
                     blk_vld_q <= 1'b0;
                     ct_rdy_q  <= 1'b1;
                     state     <= WAIT_CT;
                  end
               end
               WAIT_CT: begin
                  if (ct_in_fire) begin
                     ct_q     <= bus.ct_blk_i;
                     ct_rdy_q <= 1'b0;
                     ct_vld_q <= 1'b1;
                     word_idx <= '0;
                     state    <= UNPACK;
                  end
               end
               UNPACK: begin
                  if (ct_out_fire) begin
                     if (word_idx == LAST_WORD) begin
                        word_idx <= '0;
                        ct_vld_q <= 1'b0;
                        blk_cnt  <= blk_cnt + CNT_W'(1);
                        if ((blk_cnt + CNT_W'(1)) == num_q) begin
                           state <= DONE;
                        end else begin
                           state    <= PACK;
                           pt_rdy_q <= 1'b1;
                        end
                     end else begin
                        word_idx <= word_idx + 1'b1;
                     end
                  end
               end
               DONE: begin
                  done_o <= 1'b1;
                  state  <= IDLE;
               end
               default: state <= IDLE;
            endcase
         end
      end
   end

endmodule

// File: doc/aes_word_packer.md
AES_WORD_PACKER -- requirements
Module: aes_word_packer

Interface
REQ-001 SHALL have parameter CNT_W, default 16, width of block count and counter.
REQ-002 SHALL have clk  input  1  clock; all logic on rising edge.
REQ-003 SHALL have reset_n  input  1  asynchronous, active-low reset.
REQ-004 SHALL have clear  input  1  synchronous clear, from ctrl_engine_t.clear.
REQ-005 SHALL have start  input  1  one-cycle job start, from ctrl_engine_t.start.
REQ-006 SHALL have enable  input  1  global enable, from ctrl_engine_t.enable.
REQ-007 SHALL have num_blocks_i  input  CNT_W  number of 128-bit blocks per job.
REQ-008 SHALL have pt_data_i / pt_valid_i / pt_ready_o  in/in/out  32/1/1  plaintext word stream from the source streamer.
REQ-009 SHALL have blk_data_o / blk_valid_o / blk_ready_i  out/out/in  128/1/1  packed plaintext block to the cipher core.
REQ-010 SHALL have ct_blk_i / ct_valid_i / ct_ready_o  in/in/out  128/1/1  ciphertext block from the cipher core.
REQ-011 SHALL have ct_data_o / ct_valid_o / ct_ready_i  out/out/in  32/1/1  ciphertext word stream to the sink streamer.
REQ-012 SHALL have busy_o  output  1  high in every state except IDLE.
REQ-013 SHALL have done_o  output  1  one-cycle job-complete pulse, maps to flags_engine_t.done.

Function
REQ-014 SHALL use states IDLE, PACK, ISSUE, WAIT_CT, UNPACK, DONE.
REQ-015 SHALL, in IDLE with start=1, latch num_blocks_i, zero block and word counters, and go to PACK; go to DONE if num_blocks_i=0.
REQ-016 SHALL ignore start in every state other than IDLE.
REQ-017 SHALL, in PACK, drive pt_ready_o=1 and store word k (k=0..3) into block bits [32k+31:32k] on each pt_valid_i&pt_ready_o.
REQ-018 SHALL move from PACK to ISSUE on the cycle the 4th word is accepted, with no idle cycle between words.
REQ-019 SHALL, in ISSUE, hold blk_valid_o=1 and blk_data_o stable until blk_ready_i; then go to WAIT_CT.
REQ-020 SHALL, in WAIT_CT, drive ct_ready_o=1, capture ct_blk_i on ct_valid_i, and go to UNPACK.
REQ-021 SHALL, in UNPACK, output ct bits [31:0] first, then [63:32], [95:64], [127:96], with ct_valid_o=1 and data stable until ct_ready_i.
REQ-022 SHALL, on acceptance of the 4th word, increment the block counter; go to DONE if it equals the latched count, else go to PACK.
REQ-023 SHALL, in DONE, assert done_o for exactly one cycle, then go to IDLE.
REQ-024 SHALL, while enable=0, force pt_ready_o, blk_valid_o, ct_ready_o and ct_valid_o to 0 and freeze state, counters and data registers.
REQ-025 SHALL, on clear=1, go to IDLE next cycle and zero counters and handshake outputs; clear has priority over start and enable.
REQ-026 SHALL never assert any output valid and its ready in a combinational path from the same-side input (no ready->valid loops).

Reset
REQ-027 SHALL, on reset_n=0, enter IDLE with all outputs 0, counters 0, and data registers 0.
REQ-028 SHALL, on reset mid-job, abandon the job with no done_o pulse.

Structure
REQ-029 SHALL define aes_pack_state_t, AES_WORD_W=32 and AES_BLOCK_WORDS=4 in aes_package.
REQ-030 SHALL be a single module with no sub-modules; the counters and 128-bit registers are inline.

Verification
REQ-031 SHALL cover: num_blocks=1, words 0x03020100, 0x07060504, 0x0B0A0908, 0x0F0E0D0C -> blk_data_o=0x0F0E0D0C0B0A090807060504030201 00 (hex, W3..W0) at ISSUE.
REQ-032 SHALL cover: ct_blk_i=0x69C4E0D86A7B0430D8CDB78070B4C55A -> ct_data_o sequence 0x70B4C55A, 0xD8CDB780, 0x6A7B0430, 0x69C4E0D8, then one done_o pulse.
REQ-033 SHALL cover: num_blocks=3 with random valid/ready gaps on every interface -> exactly 12 words in and 12 out, 3 block handshakes, 1 done_o pulse.
REQ-034 SHALL cover: num_blocks=0 with start -> done_o two cycles after start, no handshakes.
REQ-035 SHALL cover: enable=0 for 5 cycles mid-UNPACK -> ct_valid_o=0, state and word index held, and the sequence resumes unchanged.
REQ-036 SHALL cover: clear asserted in WAIT_CT -> IDLE next cycle, no done_o pulse, and a new start completes correctly.
